// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes (common with the RX side), parity
// type codes and default word/counter widths.
package uart_pkg;

    localparam int UART_DATA_WD      = 8;
    localparam int UART_BIT_COUNT_WD = 3;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_START  = 3'b001,
        ST_DATA   = 3'b011,
        ST_PARITY = 3'b010,
        ST_STOP   = 3'b110
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Parallel-word side of the UART transmitter plus the serial line it drives.
// master = word source (controller / FIFO read side), slave = uart_tx.
interface uart_tx_if #(
    parameter int DATA_WD = uart_pkg::UART_DATA_WD
);
    logic [DATA_WD-1:0] P_DATA;
    logic               DATA_VALID;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic               TX_OUT;
    logic               busy;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, busy
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, busy
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Shift register and bit counter for the transmitter; load/shift/count are
// commanded by the uart_tx FSM, done flags the last data bit.
module uart_tx_serializer #(
    parameter int DATA_WD      = uart_pkg::UART_DATA_WD,
    parameter int BIT_COUNT_WD = uart_pkg::UART_BIT_COUNT_WD
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load_en,
    input  logic [DATA_WD-1:0] load_dat,
    input  logic               shift_en,
    input  logic               cnt_en,
    output logic               lsb,
    output logic               done
);

    logic [DATA_WD-1:0]      shift_d, shift_q;
    logic [BIT_COUNT_WD-1:0] cnt_d, cnt_q;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_en) begin
            shift_d = load_dat;
            cnt_d   = '0;
        end else begin
            if (shift_en) shift_d = shift_q >> 1;
            // Natural wrap from DATA_WD-1 back to 0 on the last data edge.
            if (cnt_en)   cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign lsb  = shift_q[0];
    assign done = (cnt_q == BIT_COUNT_WD'(DATA_WD - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_WD bits LSB first, optional parity, stop; one bit per CLK,
// start bit on the accepting edge; words offered while busy are dropped. UART_TX_TWO_STOP_EN: two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WD      = UART_DATA_WD,
    parameter int BIT_COUNT_WD = UART_BIT_COUNT_WD
) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  u_if
);

    uart_state_e state_d, state_q;
    logic        tx_d, tx_q;
    logic        busy_d, busy_q;
    logic        par_en_d, par_en_q;
    logic        par_bit_d, par_bit_q;
    logic        load_en, shift_en, cnt_en;
    logic        ser_lsb, ser_done;
    logic        accept;
`ifdef UART_TX_TWO_STOP_EN
    logic        stop_cnt_d, stop_cnt_q;
`endif

    assign accept = u_if.DATA_VALID && !busy_q;

    always_comb begin
        state_d   = state_q;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        cnt_en    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = stop_cnt_q;
`endif
        case (state_q)
            ST_IDLE, ST_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                if (state_q == ST_STOP && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                    state_d    = ST_STOP;
                end else
`endif
                if (accept) begin
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                    load_en   = 1'b1;
                    par_en_d  = u_if.PAR_EN;
                    par_bit_d = (^u_if.P_DATA) ^ (u_if.PAR_TYP == PAR_ODD);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d  = ST_DATA;
                tx_d     = ser_lsb;
                busy_d   = 1'b1;
                shift_en = 1'b1;
            end
            ST_DATA: begin
                shift_en = 1'b1;
                cnt_en   = 1'b1;
                busy_d   = 1'b1;
                if (!ser_done) begin
                    tx_d = ser_lsb;
                end else if (par_en_q) begin
                    state_d = ST_PARITY;
                    tx_d    = par_bit_q;
                end else begin
                    state_d = ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt_d = 1'b0;
`else
                    busy_d     = 1'b0;
`endif
                end
            end
            ST_PARITY: begin
                state_d = ST_STOP;
`ifdef UART_TX_TWO_STOP_EN
                busy_d     = 1'b1;
                stop_cnt_d = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

    uart_tx_serializer #(
        .DATA_WD      (DATA_WD),
        .BIT_COUNT_WD (BIT_COUNT_WD)
    ) u_ser (
        .CLK      (CLK),
        .RST      (RST),
        .load_en  (load_en),
        .load_dat (u_if.P_DATA),
        .shift_en (shift_en),
        .cnt_en   (cnt_en),
        .lsb      (ser_lsb),
        .done     (ser_done)
    );

    assign u_if.TX_OUT = tx_q;
    assign u_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame bit patterns, busy timing, back-to-back,
// mid-frame input changes and asynchronous reset.
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_EXTRA = 1;
`else
    localparam int STOP_EXTRA = 0;
`endif

    logic CLK;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    uart_tx_if #(.DATA_WD(8)) u_if ();

    uart_tx #(
        .DATA_WD      (8),
        .BIT_COUNT_WD (3)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .u_if (u_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        @(posedge CLK); #1;
        check({tag, " idle tx"}, 32'(u_if.TX_OUT), 32'd1);
        check({tag, " idle busy"}, 32'(u_if.busy), 32'd0);
    endtask

    // exp[i] is the line value in frame cycle i (cycle 0 = start bit).
    task automatic run_frame(input string tag, input logic [7:0] dat, input logic pe,
                             input logic pt, input logic [11:0] exp, input int len,
                             input bit hold, input logic [7:0] next_dat, input bit disturb);
        u_if.P_DATA     = dat;
        u_if.PAR_EN     = pe;
        u_if.PAR_TYP    = pt;
        u_if.DATA_VALID = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge CLK); #1;
            check($sformatf("%s tx c%0d", tag, i), 32'(u_if.TX_OUT), 32'(exp[i]));
            check($sformatf("%s busy c%0d", tag, i), 32'(u_if.busy), (i < len - 1) ? 32'd1 : 32'd0);
            if (i == 0) begin
                if (hold) u_if.P_DATA = next_dat;
                else      u_if.DATA_VALID = 1'b0;
            end
            if (disturb && i == 4) begin
                u_if.DATA_VALID = 1'b1;
                u_if.P_DATA     = 8'h3C;
                u_if.PAR_TYP    = ~pt;
                u_if.PAR_EN     = 1'b0;
            end
            if (disturb && i == 5) u_if.DATA_VALID = 1'b0;
        end
    endtask

    initial begin
        RST             = 1'b0;
        u_if.P_DATA     = '0;
        u_if.DATA_VALID = 1'b0;
        u_if.PAR_EN     = 1'b0;
        u_if.PAR_TYP    = PAR_EVEN;

        #12;
        check("reset tx", 32'(u_if.TX_OUT), 32'd1);
        check("reset busy", 32'(u_if.busy), 32'd0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        idle_check("post-reset");

        // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
        run_frame("a5_np", 8'hA5, 1'b0, PAR_EVEN, {3'b111, 8'hA5, 1'b0}, 10 + STOP_EXTRA, 0, 8'h00, 0);
        idle_check("a5_np");
        idle_check("a5_np2");

        // 0xA5 has four ones: even parity 0, odd parity 1
        run_frame("a5_even", 8'hA5, 1'b1, PAR_EVEN, {2'b11, 1'b0, 8'hA5, 1'b0}, 11 + STOP_EXTRA, 0, 8'h00, 0);
        idle_check("a5_even");
        run_frame("a5_odd", 8'hA5, 1'b1, PAR_ODD, {2'b11, 1'b1, 8'hA5, 1'b0}, 11 + STOP_EXTRA, 0, 8'h00, 0);
        idle_check("a5_odd");

        // Back-to-back: second start bit immediately follows the stop bit
        run_frame("b2b_00", 8'h00, 1'b0, PAR_EVEN, {3'b111, 8'h00, 1'b0}, 10 + STOP_EXTRA, 1, 8'hFF, 0);
        run_frame("b2b_ff", 8'hFF, 1'b0, PAR_EVEN, {3'b111, 8'hFF, 1'b0}, 10 + STOP_EXTRA, 0, 8'h00, 0);
        idle_check("b2b");

        // 0x81 even parity = 0; 0x3C and the config flip offered mid-frame must be ignored
        run_frame("x81", 8'h81, 1'b1, PAR_EVEN, {2'b11, 1'b0, 8'h81, 1'b0}, 11 + STOP_EXTRA, 0, 8'h00, 1);
        idle_check("x81_a");
        idle_check("x81_b");

        // Reset during data bit 4 of a 0x00 frame (line low there)
        u_if.P_DATA     = 8'h00;
        u_if.PAR_EN     = 1'b0;
        u_if.DATA_VALID = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(posedge CLK); #1;
            if (i == 0) u_if.DATA_VALID = 1'b0;
        end
        check("pre-rst bit4 tx", 32'(u_if.TX_OUT), 32'd0);
        check("pre-rst bit4 busy", 32'(u_if.busy), 32'd1);
        #1 RST = 1'b0;
        #1;
        check("async rst tx", 32'(u_if.TX_OUT), 32'd1);
        check("async rst busy", 32'(u_if.busy), 32'd0);
        @(posedge CLK);
        #3 RST = 1'b1;
        idle_check("after rst");
        run_frame("x55", 8'h55, 1'b0, PAR_EVEN, {3'b111, 8'h55, 1'b0}, 10 + STOP_EXTRA, 0, 8'h00, 0);
        idle_check("x55");

        // 0xFF even parity = 0; two stop cycles when the option is built in
        run_frame("ff_even", 8'hFF, 1'b1, PAR_EVEN, {2'b11, 1'b0, 8'hFF, 1'b0}, 11 + STOP_EXTRA, 0, 8'h00, 0);
        idle_check("ff_even");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the system UART; the transmit-side counterpart of the RX path.
- Accepts a parallel byte with a valid strobe and serializes it onto TX_OUT: start bit, DATA_WD data bits LSB first, optional parity bit, stop bit.
- Runs at one bit per CLK cycle; CLK is the divided baud clock from the clock divider.
- Sits between the system controller / async FIFO read side and the UART TX pin.

Parameters:
- DATA_WD, 8, width of the data word.
- BIT_COUNT_WD, 3, bit-counter width; must equal clog2(DATA_WD).

Ports:
- CLK, input, 1, transmit bit clock.
- RST, input, 1, asynchronous active-low reset.
- P_DATA, input, DATA_WD, parallel data to send.
- DATA_VALID, input, 1, P_DATA valid; accepted only when busy=0.
- PAR_EN, input, 1, 1 = parity bit inserted.
- PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
- TX_OUT, output, 1, serial line; idles high.
- busy, output, 1, frame in progress; 0 means a new word can be accepted.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous, active-low.
- Reset values: TX_OUT=1, busy=0, state=IDLE, shift register=0, bit counter=0, latched config=0. Reset mid-frame aborts immediately; the line returns high with no partial stop bit.
- Registered outputs: TX_OUT and busy are flop outputs, so there are no combinational glitches on the line.
- State encoding: IDLE=000, START=001, DATA=011, PARITY=010, STOP=110. Any other code returns to IDLE with TX_OUT=1.
- Accept rule: DATA_VALID=1 while busy=0 at a rising edge latches the following.
  - P_DATA into the shift register.
  - PAR_EN and PAR_TYP.
  - Parity bit = XOR-reduce(P_DATA) XOR PAR_TYP.
- Input stability: all inputs are don't-care after accept. Config or data changes mid-frame do not affect the current frame.
- Latency: on the accepting edge, TX_OUT goes 0 (start bit) and busy goes 1.
- START, 1 cycle: then DATA.
- DATA, DATA_WD cycles: TX_OUT = shift-register LSB. The register shifts right and the counter increments each cycle. At counter = DATA_WD-1, go to PARITY if latched PAR_EN, else STOP.
- PARITY, 1 cycle: TX_OUT = latched parity bit, then STOP.
- STOP, 1 cycle: TX_OUT=1. busy is driven 0 during this final stop cycle.
  - DATA_VALID=1 in this cycle is accepted; the next edge goes to START, giving back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- Frame length: 10 cycles without parity, 11 with parity (DATA_WD=8).
- DATA_VALID while busy=1: ignored and not queued. The upstream block must hold or re-present the word.
- Counter: wraps to 0 on leaving DATA. It is never observed outside DATA.

Optional Feature:
- UART_TX_TWO_STOP_EN defined:
  - STOP lasts 2 cycles, tracked by a 1-bit stop counter.
  - busy stays 1 in the first stop cycle and goes 0 only in the second.
  - Back-to-back accept happens in the second stop cycle.
  - Frame length is 11 without parity, 12 with parity.
- UART_TX_TWO_STOP_EN not defined: one stop bit, behaviour exactly as above.

Decomposition:
- Shared package uart_pkg:
  - state encodings (shared with the RX state naming);
  - PAR_EVEN=0 and PAR_ODD=1 constants;
  - default DATA_WD and BIT_COUNT_WD.
- Sub-module uart_tx_serializer: shift register, bit counter and done flag (counter = DATA_WD-1), with load/shift enables from the top FSM.
- Parity generation and the output mux stay in uart_tx.

Test Plan:
1. P_DATA=0xA5, PAR_EN=0, one DATA_VALID pulse → TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles. busy=1 for cycles 1-9 and 0 in the stop cycle; the line then idles at 1.
2. P_DATA=0xA5, PAR_EN=1 → parity bit 0 with PAR_TYP=0 and 1 with PAR_TYP=1. 11-cycle frame.
3. Back-to-back: 0x00 then 0xFF, with DATA_VALID held high → two contiguous frames with no idle cycle between the stop bit and the second start bit. Second frame data bits are all 1.
4. DATA_VALID pulsed with P_DATA=0x3C during the DATA bits of a 0x81 frame → 0x81 is sent intact and 0x3C is never transmitted. Change PAR_TYP mid-frame → latched parity unchanged.
5. RST asserted during data bit 4 → TX_OUT=1 and busy=0 asynchronously. After release, a fresh 0x55 frame sends correctly.
6. With UART_TX_TWO_STOP_EN: P_DATA=0xFF, PAR_EN=1, PAR_TYP=0 → parity 0, two stop cycles, busy low only in the last one. 12-cycle frame.
